// File: rtl/width_pkg.sv
// rtl/width_pkg.sv - shared defaults, types and lane placement helper for the nibble packer
package width_pkg;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_OUT_W = 16;

    typedef logic [$clog2(DEF_OUT_W / DEF_IN_W + 1) - 1:0] lane_cnt_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_e;

    // Bit offset of lane cnt; MSB-first mirrors the lane order.
    function automatic int unsigned lane_idx(
        input int unsigned cnt,
        input bit          lsb_first,
        input int unsigned in_w  = DEF_IN_W,
        input int unsigned ratio = DEF_OUT_W / DEF_IN_W
    );
        if (lsb_first) begin
            return cnt * in_w;
        end
        return (ratio - 1 - cnt) * in_w;
    endfunction

endpackage

// File: rtl/width_pack_accum.sv
// rtl/width_pack_accum.sv - partial-word accumulator with lane counter and lane placement
module width_pack_accum
    import width_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter bit LSB_FIRST = 1'b1,
    localparam int RATIO    = OUT_W / IN_W,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_accept,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_last,
    output logic             o_close,
    output logic [OUT_W-1:0] o_word,
    output logic [CNT_W-1:0] o_count
);

    localparam int OFF_W = $clog2(OUT_W);

    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_lane_cnt;
    logic [OUT_W-1:0] w_word;
    logic [OFF_W-1:0] w_off;

    // Accumulator is cleared on every close, so unwritten lanes read as zero.
    always_comb begin
        w_off  = OFF_W'(lane_idx(32'(r_lane_cnt), LSB_FIRST, IN_W, RATIO));
        w_word = r_acc;
        w_word[w_off +: IN_W] = i_data;
    end

    assign o_close = i_last | (r_lane_cnt == CNT_W'(RATIO - 1));
    assign o_word  = w_word;
    assign o_count = r_lane_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_lane_cnt <= '0;
        end else if (i_accept) begin
            if (o_close) begin
                r_acc      <= '0;
                r_lane_cnt <= '0;
            end else begin
                r_acc      <= w_word;
                r_lane_cnt <= r_lane_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/width_nibble_packer.sv
// rtl/width_nibble_packer.sv - packs IN_W-bit beats into OUT_W-bit words with valid/ready on both sides
module width_nibble_packer
    import width_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter bit LSB_FIRST = 1'b1,
    localparam int RATIO    = OUT_W / IN_W,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last
);

    if ((OUT_W % IN_W) != 0) begin : g_bad_ratio
        $error("width_nibble_packer: OUT_W must be a multiple of IN_W");
    end

    pack_state_e      r_state;
    pack_state_e      w_state_nxt;
    logic             w_accept;
    logic             w_close;
    logic             w_load;
    logic [OUT_W-1:0] w_word;
    logic [CNT_W-1:0] w_count;
    logic [OUT_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_last;

    // Ready depends only on the output slot, so a full word can drain and refill on one edge.
    assign out_valid = (r_state == ST_HOLD);
    assign in_ready  = ~out_valid | out_ready;
    assign w_accept  = in_valid & in_ready;

    width_pack_accum #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_accept (w_accept),
        .i_data   (in_data),
        .i_last   (in_last),
        .o_close  (w_close),
        .o_word   (w_word),
        .o_count  (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_accept && w_close) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_accept && w_close) begin
                    w_load = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_out_data  <= w_word;
                r_out_count <= w_count;
                r_out_last  <= in_last;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_width_nibble_packer.sv
// tb/tb_width_nibble_packer.sv - bench for width_nibble_packer, LSB-first and MSB-first instances side by side
module tb_width_nibble_packer;

    typedef struct {
        logic [15:0] d;
        int          c;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a,  in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [15:0] out_data_a,  out_data_b;
    logic [2:0]  out_count_a, out_count_b;
    logic        out_last_a,  out_last_b;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          chk_lat = 1'b0;
    bit          rand_ready = 1'b0;
    int          stalls;
    logic [3:0]  beats[$];
    word_t       qa[$];
    word_t       qb[$];
    int          drain_cyc[$];

    always #5 clk = ~clk;

    width_nibble_packer #(.IN_W(4), .OUT_W(16), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a), .out_last(out_last_a)
    );

    width_nibble_packer #(.IN_W(4), .OUT_W(16), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b), .out_last(out_last_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a word is the concatenation of the collected beats, placed by position.
    task automatic model_accept(input logic [3:0] d, input logic l);
        word_t wa, wb;
        beats.push_back(d);
        if (beats.size() == 4 || l) begin
            wa.d = '0;
            wb.d = '0;
            foreach (beats[k]) begin
                wa.d = wa.d | (16'(beats[k]) << (4 * k));
                wb.d = wb.d | (16'(beats[k]) << (4 * (3 - k)));
            end
            wa.c = beats.size();
            wb.c = beats.size();
            wa.l = l;
            wb.l = l;
            qa.push_back(wa);
            qb.push_back(wb);
            beats.delete();
            chk_lat = 1'b1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        int  w;
        bit  done;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        w    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready_a) begin
                @(posedge clk);
                #1;
                model_accept(d, l);
                if (rand_ready) out_ready = ($urandom_range(3) != 0);
                done = 1'b1;
            end else begin
                w++;
                if (w > 60) begin
                    chk("accept_timeout", 32'(in_ready_a), 32'd1);
                    done = 1'b1;
                end
                next_cycle();
            end
        end
        stalls += w;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid_a"}, 32'(out_valid_a), 32'd0);
        chk({tag, "_data_a"},  32'(out_data_a),  32'd0);
        chk({tag, "_count_a"}, 32'(out_count_a), 32'd0);
        chk({tag, "_last_a"},  32'(out_last_a),  32'd0);
        chk({tag, "_valid_b"}, 32'(out_valid_b), 32'd0);
        chk({tag, "_data_b"},  32'(out_data_b),  32'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: the presented word must always be the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_lat) begin
                chk("latency_a", 32'(out_valid_a), 32'd1);
                chk("latency_b", 32'(out_valid_b), 32'd1);
                chk_lat = 1'b0;
            end
            if (out_valid_a) begin
                if (qa.size() == 0) begin
                    chk("spurious_a", 32'(out_valid_a), 32'd0);
                end else begin
                    chk("data_a",  32'(out_data_a),  32'(qa[0].d));
                    chk("count_a", 32'(out_count_a), 32'(qa[0].c));
                    chk("last_a",  32'(out_last_a),  32'(qa[0].l));
                    if (out_ready) begin
                        void'(qa.pop_front());
                        drain_cyc.push_back(cyc);
                    end
                end
            end
            if (out_valid_b) begin
                if (qb.size() == 0) begin
                    chk("spurious_b", 32'(out_valid_b), 32'd0);
                end else begin
                    chk("data_b",  32'(out_data_b),  32'(qb[0].d));
                    chk("count_b", 32'(out_count_b), 32'(qb[0].c));
                    chk("last_b",  32'(out_last_b),  32'(qb[0].l));
                    if (out_ready) void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        stalls    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset_in_ready", 32'(in_ready_a), 32'd1);
        rst_n = 1'b1;

        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        idle(3);

        send(4'hA, 1'b0);
        idle(3);
        send(4'hB, 1'b1);
        idle(3);

        out_ready = 1'b0;
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h5;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready_a), 32'd0);
            chk("stall_valid",    32'(out_valid_a), 32'd1);
            chk("stall_data",     32'(out_data_a), 32'h4321);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(3);
        chk("stall_drained", 32'(qa.size()), 32'd0);

        drain_cyc.delete();
        stalls = 0;
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
        idle(3);
        chk("b2b_stalls", 32'(stalls), 32'd0);
        chk("b2b_words", 32'(drain_cyc.size()), 32'd2);
        if (drain_cyc.size() == 2) chk("b2b_spacing", 32'(drain_cyc[1] - drain_cyc[0]), 32'd4);

        send(4'h9, 1'b0); send(4'hA, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        beats.delete();
        qa.delete();
        qb.delete();
        chk_lat = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
        idle(3);

        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b1);
        send(4'h1, 1'b0); send(4'h2, 1'b1);
        idle(3);

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom), ($urandom_range(5) == 0));
            if ($urandom_range(7) == 0) idle($urandom_range(3));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        send(4'hF, 1'b1);
        idle(5);
        chk("final_drain_a", 32'(qa.size()), 32'd0);
        chk("final_drain_b", 32'(qb.size()), 32'd0);
        chk("final_valid", 32'(out_valid_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
